key_step_counter: RTL and testbench

//  Upstream value source for the seven-segment display stage on the DE-series board.

---
 rtl/key_step_counter.sv | 191 +++++++++++++++++++
 tb/tb_key_step_counter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/key_step_counter.sv
// Debounced pushbutton step counter feeding the seven-segment decoder and LEDR.
// Optional AUTO_STEP_EN adds an auto_en port and a periodic auto-step prescaler.
module key_step_counter #(
   parameter int unsigned WIDTH           = 4,
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned AUTO_DIV        = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             key_n,
   input  logic             dir,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
`ifdef AUTO_STEP_EN
   input  logic             auto_en,
`endif
   output logic [WIDTH-1:0] value,
   output logic             step_pulse,
   output logic             wrap,
   output logic [9:0]       ledr
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned PAD_W = 9 - WIDTH;

   if (WIDTH == 0 || WIDTH > 8 || DEBOUNCE_CYCLES == 0 || AUTO_DIV < 2) begin : g_bad_param
      $error("key_step_counter: illegal parameter value");
   end

   // Bit 1 of the encoding marks the debounced pressed level.
   typedef enum logic [1:0] {
      RELEASED     = 2'b00,
      WAIT_PRESS   = 2'b01,
      PRESSED      = 2'b10,
      WAIT_RELEASE = 2'b11
   } state_e;

   logic             sync1_q, sync2_q;
   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] value_q, value_d;
   logic             step_q, step_d;
   logic             wrap_q, wrap_d;
   logic             key_step_c;
   logic             step_c;
   logic             ks;
   logic             cnt_done;

   assign ks       = sync2_q;
   assign cnt_done = (cnt_q == CNT_W'(DEBOUNCE_CYCLES));

   // Two-flop synchroniser; reset forces the released level.
   always_ff @(posedge clock) begin
      if (reset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= key_n;
         sync2_q <= sync1_q;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= RELEASED;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         RELEASED: begin
            if (!ks) begin
               state_d = WAIT_PRESS;
               cnt_d   = CNT_W'(1);
            end
         end
         WAIT_PRESS: begin
            if (ks) begin
               state_d = RELEASED;
               cnt_d   = '0;
            end else if (cnt_done) begin
               state_d = PRESSED;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         PRESSED: begin
            if (ks) begin
               state_d = WAIT_RELEASE;
               cnt_d   = CNT_W'(1);
            end
         end
         WAIT_RELEASE: begin
            if (!ks) begin
               state_d = PRESSED;
               cnt_d   = '0;
            end else if (cnt_done) begin
               state_d = RELEASED;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = RELEASED;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      key_step_c = (state_q == WAIT_PRESS) && !ks && cnt_done;
   end

`ifdef AUTO_STEP_EN
   localparam int unsigned PRE_W = $clog2(AUTO_DIV);

   logic [PRE_W-1:0] pre_q, pre_d;
   logic             pre_wrap_c;

   assign pre_wrap_c = (pre_q == PRE_W'(AUTO_DIV - 1));

   // Prescaler runs only while auto_en is set and is parked at 0 otherwise.
   always_comb begin
      pre_d = pre_q;
      if (!auto_en) begin
         pre_d = '0;
      end else if (pre_wrap_c) begin
         pre_d = '0;
      end else begin
         pre_d = pre_q + PRE_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pre_q <= '0;
      end else begin
         pre_q <= pre_d;
      end
   end

   assign step_c = key_step_c | (auto_en & pre_wrap_c);
`else
   assign step_c = key_step_c;
`endif

   // Load wins over a coincident step; the step is discarded.
   always_comb begin
      value_d = value_q;
      step_d  = 1'b0;
      wrap_d  = 1'b0;
      if (load) begin
         value_d = load_value;
      end else if (step_c) begin
         step_d = 1'b1;
         if (dir) begin
            value_d = value_q - WIDTH'(1);
            wrap_d  = (value_q == '0);
         end else begin
            value_d = value_q + WIDTH'(1);
            wrap_d  = (value_q == '1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         value_q <= '0;
         step_q  <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         value_q <= value_d;
         step_q  <= step_d;
         wrap_q  <= wrap_d;
      end
   end

   assign value      = value_q;
   assign step_pulse = step_q;
   assign wrap       = wrap_q;
   assign ledr       = {state_q[1], {PAD_W{1'b0}}, value_q};

endmodule

// File: tb/tb_key_step_counter.sv
// Scoreboard bench for key_step_counter: stimulus queues expected steps, a monitor checks them.
module tb_key_step_counter;

   logic       clock = 1'b0;
   logic       reset;
   logic       key_n;
   logic       dir;
   logic       load;
   logic [3:0] load_value;
`ifdef AUTO_STEP_EN
   logic       auto_en;
`endif
   logic [3:0] value;
   logic       step_pulse;
   logic       wrap;
   logic [9:0] ledr;

   key_step_counter dut (
      .clock      (clock),
      .reset      (reset),
      .key_n      (key_n),
      .dir        (dir),
      .load       (load),
      .load_value (load_value),
`ifdef AUTO_STEP_EN
      .auto_en    (auto_en),
`endif
      .value      (value),
      .step_pulse (step_pulse),
      .wrap       (wrap),
      .ledr       (ledr)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      int val;
      int wr;
      int cy;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic expect_step(input int delay, input int v, input int w);
      exp_t e;
      e.val = v;
      e.wr  = w;
      e.cy  = cyc + delay;
      q.push_back(e);
   endtask

   // Clean press from a negedge: pulse lands 7 negedges later (6 clocks after first low sample).
   task automatic press(input int hold, input int v, input int w);
      expect_step(7, v, w);
      key_n = 1'b0;
      tick(hold);
      key_n = 1'b1;
      tick(12);
   endtask

   always @(negedge clock) begin
      exp_t e;
      if (step_pulse === 1'b1) begin
         if (q.size() == 0) begin
            check("unexpected_step", 1, 0);
         end else begin
            e = q.pop_front();
            check("step_value", 32'(value), 32'(e.val));
            check("step_wrap", 32'(wrap), 32'(e.wr));
            check("step_cycle", 32'(cyc), 32'(e.cy));
         end
      end else if (wrap === 1'b1) begin
         check("stray_wrap", 1, 0);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      reset      = 1'b1;
      key_n      = 1'b1;
      dir        = 1'b0;
      load       = 1'b0;
      load_value = 4'h0;
`ifdef AUTO_STEP_EN
      auto_en    = 1'b0;
`endif
      tick(3);
      check("reset_value", 32'(value), 0);
      check("reset_step", 32'(step_pulse), 0);
      check("reset_wrap", 32'(wrap), 0);
      check("reset_ledr", 32'(ledr), 0);
      reset = 1'b0;
      tick(2);

      // Long clean press, up
      expect_step(7, 1, 0);
      key_n = 1'b0;
      tick(10);
      check("held_ledr9", 32'(ledr[9]), 1);
      tick(10);
      key_n = 1'b1;
      tick(12);
      check("press_value", 32'(value), 1);
      check("press_ledr", 32'(ledr), 32'h001);

      // Bounce: low 3, high 1, low 2, high
      key_n = 1'b0; tick(3);
      key_n = 1'b1; tick(1);
      key_n = 1'b0; tick(2);
      key_n = 1'b1; tick(12);
      check("bounce_value", 32'(value), 1);
      check("bounce_ledr", 32'(ledr), 32'h001);

      // Wrap up from F, then wrap down from 0
      load       = 1'b1;
      load_value = 4'hF;
      tick(1);
      load = 1'b0;
      check("load_value", 32'(value), 15);
      press(10, 0, 1);
      check("wrap_up_value", 32'(value), 0);
      dir = 1'b1;
      press(10, 15, 1);
      check("wrap_down_value", 32'(value), 15);
      dir = 1'b0;

      // Load coincides with the step edge
      key_n = 1'b0;
      tick(6);
      load       = 1'b1;
      load_value = 4'h3;
      tick(1);
      load = 1'b0;
      check("load_prio_value", 32'(value), 3);
      check("load_prio_step", 32'(step_pulse), 0);
      check("load_prio_ledr9", 32'(ledr[9]), 1);
      tick(4);
      key_n = 1'b1;
      tick(12);
      check("load_prio_after", 32'(value), 3);

      // Reset while key held: one step before, exactly one re-debounced step after
      expect_step(7, 4, 0);
      key_n = 1'b0;
      tick(10);
      reset = 1'b1;
      tick(2);
      check("held_reset_ledr", 32'(ledr), 0);
      reset = 1'b0;
      expect_step(7, 1, 0);
      tick(12);
      key_n = 1'b1;
      tick(12);
      check("held_reset_value", 32'(value), 1);

      reset = 1'b1;
      tick(2);
      reset = 1'b0;
`ifdef AUTO_STEP_EN
      auto_en = 1'b1;
      for (int k = 1; k <= 5; k++) expect_step(8 * k, k, 0);
      tick(40);
      auto_en = 1'b0;
      tick(2);
      check("auto_value", 32'(value), 5);
`else
      tick(40);
      check("no_auto_value", 32'(value), 0);
`endif

      tick(2);
      check("queue_empty", 32'(q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
